// File: rtl/mult_div_unit_if.sv
// Start/busy/done handshake, operands and HI/LO results between the control unit and mult_div_unit.
// The control unit holds the master modport; the engine holds the slave modport.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply-divide owning HI/LO; done pulses WIDTH+3 edges after start (2 on divide-by-zero).
// No backpressure: start, mthi and mtlo are ignored while busy, and start takes priority over mthi/mtlo in IDLE.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               neg_r;

  logic accept;
  logic direct_wr;
  logic load_en;
  logic iter_en;
  logic fix_en;
  logic fin_en;

  logic               is_div;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               b_zero;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] iter_acc;
  logic [2*WIDTH-1:0] fix_acc;

  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];

  // Raw a sits in acc's low half and raw b in opnd until LOAD turns them into magnitudes.
  always_comb begin
    a_neg     = is_signed & acc[WIDTH-1];
    b_neg     = is_signed & opnd[WIDTH-1];
    a_abs     = a_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    b_abs     = b_neg ? (~opnd + 1'b1) : opnd;
    b_zero    = (opnd == '0);
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, opnd};
    iter_acc  = '0;
    if (is_div) begin
      if (!div_trial[WIDTH+1]) begin
        iter_acc = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        iter_acc = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_acc = {mul_sum, acc[WIDTH-1:1]};
    end
    fix_acc = acc;
    if (is_div) begin
      fix_acc[WIDTH-1:0]       = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      fix_acc[2*WIDTH-1:WIDTH] = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      fix_acc = ~acc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = (is_div && b_zero) ? FIN : ITER;
      ITER:    if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && bus.start;
    direct_wr = (state == IDLE) && !bus.start;
    load_en   = (state == LOAD);
    iter_en   = (state == ITER);
    fix_en    = (state == FIX);
    fin_en    = (state == FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r         <= '0;
      opnd         <= '0;
      acc          <= '0;
      cnt          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi       <= '0;
      bus.lo       <= '0;
    end else begin
      bus.done <= fin_en;
      if (accept) begin
        op_r         <= bus.op;
        acc          <= {{WIDTH{1'b0}}, bus.a};
        opnd         <= bus.b;
        bus.busy     <= 1'b1;
        bus.div_zero <= 1'b0;
      end
      if (direct_wr && bus.mthi) bus.hi <= bus.wdata;
      if (direct_wr && bus.mtlo) bus.lo <= bus.wdata;
      if (load_en) begin
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        cnt   <= CNT_W'(WIDTH);
        // Multiplier goes in the low half so it shifts out as the product shifts in.
        if (is_div) begin
          acc  <= {{WIDTH{1'b0}}, a_abs};
          opnd <= b_abs;
          if (b_zero) bus.div_zero <= 1'b1;
        end else begin
          acc  <= {{WIDTH{1'b0}}, b_abs};
          opnd <= a_abs;
        end
      end
      if (iter_en) begin
        acc <= iter_acc;
        cnt <= cnt - CNT_W'(1);
      end
      if (fix_en) acc <= fix_acc;
      if (fin_en) begin
        bus.busy <= 1'b0;
        if (!bus.div_zero) begin
          bus.hi <= acc[2*WIDTH-1:WIDTH];
          bus.lo <= acc[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Table-driven and hand-sequenced checks of mult_div_unit with a queue scoreboard popped on each done pulse.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 3;

  logic clk;
  logic reset;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  exp_t sb [$];
  exp_t e;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && bus.done) begin
      done_cnt++;
      chk("done_single_pulse", {63'd0, prev_done}, 64'd0);
      chk("busy_low_at_done", {63'd0, bus.busy}, 64'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done with empty scoreboard expected none");
      end else begin
        e = sb.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
      end
    end
    prev_done = bus.done;
  end

  // Drives start immediately; returns #1 after the edge that samples it.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input logic mth, input logic mtl, input logic [W-1:0] wd, output int t0);
    exp_t x;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.mthi  = mth;
    bus.mtlo  = mtl;
    bus.wdata = wd;
    x.hi = ehi;
    x.lo = elo;
    x.dz = edz;
    sb.push_back(x);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    t0 = cyc;
    chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
  endtask

  // Returns on the negedge where done is high, so a following launch lands in the done cycle.
  task automatic await_done(input int t0, input int lat, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 500);
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end else begin
      chk(name, 64'(cyc - t0), 64'(lat));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6]  = '{2'b00, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD};
    vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[10] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[11] = '{2'b00, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[12] = '{2'b11, 32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000};

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    #2;
    chk("reset_hi", bus.hi, 0);
    chk("reset_lo", bus.lo, 0);
    chk("reset_busy", {63'd0, bus.busy}, 0);
    chk("reset_done", {63'd0, bus.done}, 0);
    chk("reset_div_zero", {63'd0, bus.div_zero}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, 1'b0, 1'b0, '0, t0);
      await_done(t0, LAT, "latency");
      model_hi = vecs[i].hi;
      model_lo = vecs[i].lo;
    end

    // mthi in IDLE, then divide by zero leaves HI/LO alone and sets the sticky flag.
    @(negedge clk);
    bus.mthi  = 1'b1;
    bus.wdata = 32'hAAAA5555;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    chk("mthi_idle", bus.hi, 32'hAAAA5555);
    model_hi = 32'hAAAA5555;
    @(negedge clk);
    launch(2'b10, 32'd5, 32'd0, model_hi, model_lo, 1'b1, 1'b0, 1'b0, '0, t0);
    await_done(t0, 2, "latency_div_zero");
    repeat (3) @(negedge clk);
    chk("div_zero_sticky", {63'd0, bus.div_zero}, 1);
    launch(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0, 1'b0, '0, t0);
    chk("div_zero_cleared_on_start", {63'd0, bus.div_zero}, 0);
    await_done(t0, LAT, "latency");
    model_hi = 32'd0;
    model_lo = 32'd6;

    // start with mtlo in IDLE: the direct write is dropped.
    launch(2'b11, 32'd9, 32'd0, model_hi, model_lo, 1'b1, 1'b0, 1'b1, 32'h12345678, t0);
    await_done(t0, 2, "latency_div_zero_mtlo");

    // mthi and mtlo together write both.
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mthi_mtlo_hi", bus.hi, 32'h5A5A5A5A);
    chk("mthi_mtlo_lo", bus.lo, 32'h5A5A5A5A);

    // start/mtlo/op changes while busy must not disturb the running MULT.
    @(negedge clk);
    launch(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0, 1'b0, '0, t0);
    bus.a = 32'h00001234;
    foreach (vecs[k]) begin
      if (k < 2) begin
        int at;
        at = (k == 0) ? 5 : 20;
        while (cyc < t0 + at - 1) @(negedge clk);
        bus.start = 1'b1;
        bus.mtlo  = 1'b1;
        bus.op    = 2'b11;
        bus.b     = 32'd0;
        bus.wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        chk("mtlo_while_busy", bus.lo, 32'h5A5A5A5A);
      end
    end
    await_done(t0, LAT, "latency_with_ignored_start");

    // Async reset mid-operation abandons it with no done pulse.
    launch(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0, 1'b0, '0, t0);
    while (cyc < t0 + 9) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_hi", bus.hi, 0);
    chk("async_reset_lo", bus.lo, 0);
    chk("async_reset_busy", {63'd0, bus.busy}, 0);
    sb.delete();
    begin
      int dc;
      dc = done_cnt;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (50) @(negedge clk);
      chk("no_done_after_reset", 64'(done_cnt), 64'(dc));
      chk("idle_after_reset_busy", {63'd0, bus.busy}, 0);
    end

    launch(2'b00, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0, 1'b0, 1'b0, '0, t0);
    await_done(t0, LAT, "latency_after_reset");
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
